// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with programmable modulus, wrap or saturate at the
// bounds, registered overflow/underflow pulses and combinational terminal/zero flags.
module updown_counter_param #(
    parameter int WIDTH    = 6,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int TC_VAL   = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] po,
    output logic             tc,
    output logic             zero,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   TC_EXT  = (WIDTH+1)'(TC_VAL);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;

    // One extra bit keeps MAX_VAL = 2**WIDTH-1 +1 and 0 -1 visible to the bound checks.
    assign count_ext = {1'b0, count_reg};
    assign up_sum    = count_ext + ONE_EXT;
    assign dn_diff   = count_ext - ONE_EXT;

    always_comb begin
        count_next = count_reg;
        ovf_next   = 1'b0;
        udf_next   = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (ld) begin
            count_next = ({1'b0, pi} > MAX_EXT) ? MAX_W : pi;
        end else if (inc && !dec) begin
            if (up_sum > MAX_EXT) begin
                ovf_next   = 1'b1;
                count_next = SATURATE ? MAX_W : '0;
            end else begin
                count_next = up_sum[WIDTH-1:0];
            end
        end else if (dec && !inc) begin
            if (dn_diff[WIDTH]) begin
                udf_next   = 1'b1;
                count_next = SATURATE ? '0 : MAX_W;
            end else begin
                count_next = dn_diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    assign po   = count_reg;
    assign ovf  = ovf_reg;
    assign udf  = udf_reg;
    assign tc   = (count_ext == TC_EXT);
    assign zero = (count_reg == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: default 6-bit instance plus 4-bit modulus-10
// instances in wrap and saturate mode, driven by a vector table, hand sequences and random stimulus.
module tb_updown_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Default instance (6-bit, MAX 63, TC 32, wrap)
    logic       r0 = 0, c0 = 0, l0 = 0, i0 = 0, d0 = 0;
    logic [5:0] pi0 = '0;
    logic [5:0] po0;
    logic       tc0, z0, ov0, ud0;

    // Shared stimulus for the two 4-bit modulus-10 instances
    logic       r1 = 0, c1 = 0, l1 = 0, i1 = 0, d1 = 0;
    logic [3:0] pi1 = '0;
    logic [3:0] po1, po2;
    logic       tc1, z1, ov1, ud1, tc2, z2, ov2, ud2;

    updown_counter_param dut0 (
        .clk(clk), .rst(r0), .clr(c0), .ld(l0), .inc(i0), .dec(d0), .pi(pi0),
        .po(po0), .tc(tc0), .zero(z0), .ovf(ov0), .udf(ud0)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .TC_VAL(9), .SATURATE(1'b0)) dut1 (
        .clk(clk), .rst(r1), .clr(c1), .ld(l1), .inc(i1), .dec(d1), .pi(pi1),
        .po(po1), .tc(tc1), .zero(z1), .ovf(ov1), .udf(ud1)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .TC_VAL(9), .SATURATE(1'b1)) dut2 (
        .clk(clk), .rst(r1), .clr(c1), .ld(l1), .inc(i1), .dec(d1), .pi(pi1),
        .po(po2), .tc(tc2), .zero(z2), .ovf(ov2), .udf(ud2)
    );

    typedef struct {
        logic       rst, clr, ld, inc, dec;
        logic [3:0] pi;
        int         po;
        logic       tc, zero, ovf, udf;
    } vec_t;

    vec_t tbl [12];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the counter's rules stated directly on an integer count.
    function automatic void model(input bit rst_i, input bit clr_i, input bit ld_i,
                                  input bit inc_i, input bit dec_i, input int pi_i,
                                  input int maxv, input bit sat,
                                  inout int cnt, output bit ov, output bit ud);
        ov = 1'b0;
        ud = 1'b0;
        if (rst_i || clr_i) cnt = 0;
        else if (ld_i) cnt = (pi_i > maxv) ? maxv : pi_i;
        else if (inc_i && !dec_i) begin
            if (cnt == maxv) begin ov = 1'b1; cnt = sat ? maxv : 0; end
            else cnt = cnt + 1;
        end else if (dec_i && !inc_i) begin
            if (cnt == 0) begin ud = 1'b1; cnt = sat ? 0 : maxv; end
            else cnt = cnt - 1;
        end
    endfunction

    task automatic set1(input bit r, input bit c, input bit l, input bit i, input bit d, input int p);
        r1 = r; c1 = c; l1 = l; i1 = i; d1 = d; pi1 = 4'(p);
    endtask

    task automatic set0(input bit r, input bit c, input bit l, input bit i, input bit d, input int p);
        r0 = r; c0 = c; l0 = l; i0 = i; d0 = d; pi0 = 6'(p);
    endtask

    initial begin
        int  m0, m1, m2;
        bit  eo0, eu0, eo1, eu1, eo2, eu2;
        bit  rr, rc, rl, ri, rd;
        int  rp0, rp1;

        // ---------------- table-driven vectors on the wrap-mode 4-bit instance
        //            rst clr ld inc dec pi   po  tc zero ovf udf
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 9, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  9, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  8, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd10, 9, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  0, 1'b0, 1'b1, 1'b0, 1'b0};

        set0(1, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        tick();

        for (int k = 0; k < 12; k++) begin
            set1(tbl[k].rst, tbl[k].clr, tbl[k].ld, tbl[k].inc, tbl[k].dec, int'(tbl[k].pi));
            tick();
            $display("[TB] vec %0d: rst=%0b clr=%0b ld=%0b inc=%0b dec=%0b pi=%0d -> po=%0d tc=%0b zero=%0b ovf=%0b udf=%0b",
                     k, r1, c1, l1, i1, d1, pi1, po1, tc1, z1, ov1, ud1);
            chk($sformatf("vec%0d_po", k),   int'(po1), tbl[k].po);
            chk($sformatf("vec%0d_tc", k),   int'(tc1), int'(tbl[k].tc));
            chk($sformatf("vec%0d_zero", k), int'(z1),  int'(tbl[k].zero));
            chk($sformatf("vec%0d_ovf", k),  int'(ov1), int'(tbl[k].ovf));
            chk($sformatf("vec%0d_udf", k),  int'(ud1), int'(tbl[k].udf));
        end

        // ---------------- default instance: count through the carry-out and the wrap
        set0(1, 0, 0, 0, 0, 0);
        tick();
        chk("d0_reset_po", int'(po0), 0);
        chk("d0_reset_zero", int'(z0), 1);
        chk("d0_reset_tc", int'(tc0), 0);
        set0(0, 0, 0, 1, 0, 0);
        for (int n = 1; n <= 63; n++) begin
            tick();
            chk($sformatf("d0_up%0d_po", n), int'(po0), n);
            chk($sformatf("d0_up%0d_tc", n), int'(tc0), (n == 32) ? 1 : 0);
            chk($sformatf("d0_up%0d_ovf", n), int'(ov0), 0);
        end
        $display("[TB] d0 counted up: po=%0d", po0);
        tick();
        chk("d0_wrap_po", int'(po0), 0);
        chk("d0_wrap_ovf", int'(ov0), 1);
        chk("d0_wrap_zero", int'(z0), 1);
        tick();
        chk("d0_after_wrap_po", int'(po0), 1);
        chk("d0_after_wrap_ovf", int'(ov0), 0);

        // ---------------- wrap-mode 4-bit: ld 7 then 8 down-steps
        set1(0, 0, 1, 0, 0, 7);
        tick();
        chk("w_ld7_po", int'(po1), 7);
        set1(0, 0, 0, 0, 1, 0);
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk($sformatf("w_dn%0d_po", n), int'(po1), (n == 8) ? 9 : 7 - n);
            chk($sformatf("w_dn%0d_udf", n), int'(ud1), (n == 8) ? 1 : 0);
        end
        set1(0, 0, 1, 0, 0, 15);
        tick();
        chk("w_ld15_po", int'(po1), 9);
        chk("w_ld15_tc", int'(tc1), 1);
        chk("w_ld15_udf", int'(ud1), 0);

        // ---------------- saturate-mode 4-bit: ld 8, hold inc for 4 cycles
        set1(0, 0, 1, 0, 0, 8);
        tick();
        chk("s_ld8_po", int'(po2), 8);
        set1(0, 0, 0, 1, 0, 0);
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk($sformatf("s_up%0d_po", n), int'(po2), 9);
            chk($sformatf("s_up%0d_ovf", n), int'(ov2), (n == 1) ? 0 : 1);
        end
        set1(0, 0, 0, 0, 0, 0);
        tick();
        chk("s_idle_ovf", int'(ov2), 0);
        set1(0, 1, 0, 0, 0, 0);
        tick();
        set1(0, 0, 0, 0, 1, 0);
        tick();
        chk("s_dn0_po", int'(po2), 0);
        chk("s_dn0_udf", int'(ud2), 1);
        tick();
        chk("s_dn0b_udf", int'(ud2), 1);

        // ---------------- reset mid-run on the default instance
        set0(1, 0, 0, 0, 0, 0);
        tick();
        set0(0, 0, 0, 1, 0, 0);
        repeat (40) tick();
        chk("rr_po40", int'(po0), 40);
        set0(1, 0, 1, 1, 0, 20);
        tick();
        chk("rr_po", int'(po0), 0);
        chk("rr_ovf", int'(ov0), 0);
        chk("rr_udf", int'(ud0), 0);
        set0(0, 0, 0, 1, 0, 0);
        tick();
        chk("rr_release_po", int'(po0), 1);

        // ---------------- randomised run against the reference model
        set0(1, 0, 0, 0, 0, 0);
        set1(1, 0, 0, 0, 0, 0);
        tick();
        m0 = 0; m1 = 0; m2 = 0;
        for (int n = 0; n < 10000; n++) begin
            bit up_bias;
            up_bias = ((n / 300) % 2) == 0;
            rr = ($urandom_range(255) == 0);
            rc = ($urandom_range(40) == 0);
            rl = ($urandom_range(20) == 0);
            ri = up_bias ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rd = up_bias ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            rp0 = int'($urandom_range(63));
            rp1 = int'($urandom_range(15));
            set0(rr, rc, rl, ri, rd, rp0);
            set1(rr, rc, rl, ri, rd, rp1);
            model(rr, rc, rl, ri, rd, rp0, 63, 1'b0, m0, eo0, eu0);
            model(rr, rc, rl, ri, rd, rp1, 9, 1'b0, m1, eo1, eu1);
            model(rr, rc, rl, ri, rd, rp1, 9, 1'b1, m2, eo2, eu2);
            tick();
            chk("rnd0_po", int'(po0), m0);
            chk("rnd0_tc", int'(tc0), (m0 == 32) ? 1 : 0);
            chk("rnd0_zero", int'(z0), (m0 == 0) ? 1 : 0);
            chk("rnd0_ovf", int'(ov0), int'(eo0));
            chk("rnd0_udf", int'(ud0), int'(eu0));
            chk("rnd1_po", int'(po1), m1);
            chk("rnd1_range", (int'(po1) <= 9) ? 1 : 0, 1);
            chk("rnd1_tc", int'(tc1), (m1 == 9) ? 1 : 0);
            chk("rnd1_zero", int'(z1), (m1 == 0) ? 1 : 0);
            chk("rnd1_ovf", int'(ov1), int'(eo1));
            chk("rnd1_udf", int'(ud1), int'(eu1));
            chk("rnd2_po", int'(po2), m2);
            chk("rnd2_range", (int'(po2) <= 9) ? 1 : 0, 1);
            chk("rnd2_tc", int'(tc2), (m2 == 9) ? 1 : 0);
            chk("rnd2_zero", int'(z2), (m2 == 0) ? 1 : 0);
            chk("rnd2_ovf", int'(ov2), int'(eo2));
            chk("rnd2_udf", int'(ud2), int'(eu2));
        end
        $display("[TB] random phase done: final po0=%0d po1=%0d po2=%0d", po0, po1, po2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
